// File: rtl/raster_frame_sched.sv
// raster_frame_sched: per-frame controller that clears FB/ZB, feeds triangles to the rasterizer and signals frame completion.
//   clk, rst_n                 clock, asynchronous active-low reset
//   frame_start/clear_en/num_tris  frame request, clear enable and triangle count (sampled in IDLE)
//   frame_busy/frame_done      frame in progress / one-cycle end-of-frame pulse
//   tri_valid/tri_ready/tri_data   upstream triangle handshake
//   rast_valid/rast_tri/rast_busy  rasterizer triangle handshake
//   r_fb_*/r_zb_*              rasterizer buffer writes; fb_*/zb_* muxed buffer write ports
//   tris_done/tris_culled      per-frame saturating triangle counters
module raster_frame_sched #(
    parameter int          FB_DEPTH       = 76800,
    parameter int          ADDR_W         = 17,
    parameter int          TRI_W          = 312,
    parameter logic [11:0] CLEAR_COLOR    = 12'h000,
    parameter logic [7:0]  CLEAR_Z        = 8'hFF,
    parameter int          ACCEPT_TIMEOUT = 16,
    parameter int          DRAIN_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              clear_en,
    input  logic [15:0]       num_tris,
    output logic              frame_busy,
    output logic              frame_done,
    input  logic              tri_valid,
    output logic              tri_ready,
    input  logic [TRI_W-1:0]  tri_data,
    output logic              rast_valid,
    output logic [TRI_W-1:0]  rast_tri,
    input  logic              rast_busy,
    input  logic [ADDR_W-1:0] r_fb_addr,
    input  logic              r_fb_we,
    input  logic [11:0]       r_fb_pixel,
    input  logic [ADDR_W-1:0] r_zb_w_addr,
    input  logic              r_zb_we,
    input  logic [7:0]        r_zb_w_data,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [11:0]       fb_pixel,
    output logic [ADDR_W-1:0] zb_w_addr,
    output logic              zb_we,
    output logic [7:0]        zb_w_data,
    output logic [15:0]       tris_done,
    output logic [15:0]       tris_culled
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, ISSUE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] clr_addr;
    logic [15:0] remaining, cnt;
    logic clearing, clr_last, issue_timeout, drain_last;
    assign clearing      = state == CLEAR;
    assign clr_last      = clr_addr == ADDR_W'(FB_DEPTH - 1);
    // cnt is shared: accept timeout in ISSUE, drain length in DRAIN
    assign issue_timeout = cnt == 16'(ACCEPT_TIMEOUT - 1);
    assign drain_last    = cnt == 16'(DRAIN_CYCLES - 1);
    assign frame_busy    = state != IDLE;
    assign frame_done    = state == DONE;
    assign tri_ready     = state == FETCH && remaining != 16'd0;
    assign rast_valid    = state == ISSUE;
    // clear engine owns both write ports during CLEAR, otherwise the rasterizer passes straight through
    assign fb_addr       = clearing ? clr_addr : r_fb_addr;
    assign fb_we         = clearing | r_fb_we;
    assign fb_pixel      = clearing ? CLEAR_COLOR : r_fb_pixel;
    assign zb_w_addr     = clearing ? clr_addr : r_zb_w_addr;
    assign zb_we         = clearing | r_zb_we;
    assign zb_w_data     = clearing ? CLEAR_Z : r_zb_w_data;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = frame_start ? (clear_en ? CLEAR : FETCH) : IDLE;
            CLEAR:   state_n = clr_last ? FETCH : CLEAR;
            FETCH:   state_n = remaining == 16'd0 ? DRAIN : (tri_valid ? ISSUE : FETCH);
            ISSUE:   state_n = rast_busy ? RUN : (issue_timeout ? FETCH : ISSUE);
            RUN:     state_n = rast_busy ? RUN : FETCH;
            DRAIN:   state_n = drain_last ? DONE : DRAIN;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr    <= '0;
            cnt         <= '0;
            remaining   <= '0;
            tris_done   <= '0;
            tris_culled <= '0;
            rast_tri    <= '0;
        end else begin
            clr_addr <= (clearing && !clr_last) ? clr_addr + ADDR_W'(1) : '0;
            cnt      <= ((state == ISSUE || state == DRAIN) && state_n == state) ? cnt + 16'd1 : '0;
            if (state == IDLE && frame_start) begin
                remaining   <= num_tris;
                tris_done   <= '0;
                tris_culled <= '0;
            end
            if (tri_ready && tri_valid) rast_tri <= tri_data;
            if (state == ISSUE && !rast_busy && issue_timeout) begin
                remaining   <= remaining - 16'd1;
                tris_culled <= tris_culled + 16'(tris_culled != 16'hFFFF);
            end
            if (state == RUN && !rast_busy) begin
                remaining <= remaining - 16'd1;
                tris_done <= tris_done + 16'(tris_done != 16'hFFFF);
            end
        end
    end
endmodule

// File: doc/raster_frame_sched.md
Name: raster_frame_sched

Overview:
- Per-frame controller that owns the rasterizer and the shared frame-buffer/Z-buffer write ports.
- On a frame request it first clears both buffers: FB to CLEAR_COLOR, ZB to CLEAR_Z (far plane).
- It then dispatches a counted stream of packed triangles into the rasterizer using the rasterizer's valid/busy handshake.
- After the last triangle it waits for the pixel pipeline to drain and pulses frame-done. It sits between the scene/geometry front end and the rasterizer plus buffer memories.

Parameters:
- FB_DEPTH, 76800, pixels per buffer (320x240); clear covers addresses 0..FB_DEPTH-1.
- ADDR_W, 17, FB/ZB address width.
- TRI_W, 312, packed triangle width: {x0,y0,x1,y1,x2,y2 (6x16), z0,z1,z2 (3x8), u0,v0,u1,v1,u2,v2 (6x32)}.
- CLEAR_COLOR, 12'h000, 4R4G4B clear value.
- CLEAR_Z, 8'hFF, Z clear value.
- ACCEPT_TIMEOUT, 16, cycles to wait for rasterizer busy before declaring a triangle culled.
- DRAIN_CYCLES, 8, cycles held after final busy fall, covering post-iterator pipeline stages.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle frame request
- i_clear_en  in  1  sampled with i_frame_start; 0 skips the clear
- i_num_tris  in  16  triangle count, sampled with i_frame_start
- o_frame_busy  out  1  high from accepted frame start until frame done
- o_frame_done  out  1  one-cycle pulse at end of frame
- i_tri_valid  in  1  upstream triangle valid
- o_tri_ready  out  1  scheduler can take a triangle
- i_tri_data  in  TRI_W  packed triangle
- o_rast_valid  out  1  to rasterizer i_tri_valid
- o_rast_tri  out  TRI_W  registered triangle to rasterizer vertex inputs
- i_rast_busy  in  1  rasterizer o_busy
- i_r_fb_addr/i_r_fb_we/i_r_fb_pixel  in  ADDR_W/1/12  rasterizer FB write
- i_r_zb_w_addr/i_r_zb_we/i_r_zb_w_data  in  ADDR_W/1/8  rasterizer ZB write
- o_fb_addr/o_fb_we/o_fb_pixel  out  ADDR_W/1/12  muxed FB write port
- o_zb_w_addr/o_zb_we/o_zb_w_data  out  ADDR_W/1/8  muxed ZB write port
- o_tris_done  out  16  triangles rasterized this frame
- o_tris_culled  out  16  triangles that timed out on accept

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including the counters and o_rast_tri.
  - A reset mid-frame aborts immediately. No done pulse is produced and the partial clear is left in memory.
- States and transitions:
  - IDLE. On i_frame_start, latch the frame parameters, zero the counters and raise o_frame_busy. Then go to CLEAR if i_clear_en, else FETCH. i_frame_start in any other state is ignored.
  - CLEAR. Write both buffers at the same address every cycle for FB_DEPTH cycles, counting 0..FB_DEPTH-1 (o_fb_we=o_zb_we=1, data=CLEAR_COLOR/CLEAR_Z). After address FB_DEPTH-1, go to FETCH; no extra write.
  - FETCH. If the remaining count is 0, go to DRAIN. Otherwise o_tri_ready=1. When i_tri_valid&&o_tri_ready, register i_tri_data into o_rast_tri and go to ISSUE.
  - ISSUE. o_rast_valid=1, held until i_rast_busy is sampled 1, then go to RUN with o_rast_valid deasserted the next cycle. If ACCEPT_TIMEOUT cycles pass without busy, increment o_tris_culled, decrement remaining, drop valid and return to FETCH.
  - RUN. Wait for i_rast_busy=0, then increment o_tris_done, decrement remaining and go to FETCH.
  - DRAIN. Count DRAIN_CYCLES, then go to DONE.
  - DONE. Pulse o_frame_done for 1 cycle, clear o_frame_busy and go to IDLE.
- o_tri_ready is combinational from state (FETCH and remaining≠0). o_rast_tri is stable whenever o_rast_valid=1.
- Write-port mux:
  - In CLEAR, the muxed ports are driven by the clear engine and all i_r_* are ignored.
  - In every other state the outputs pass i_r_* combinationally (zero added latency).
  - The ZB read port is not owned by this block.
- Arithmetic:
  - The clear counter is ADDR_W bits and never exceeds FB_DEPTH-1.
  - Triangle counters saturate at 16'hFFFF.
  - o_tris_done + o_tris_culled = i_num_tris at o_frame_done.
- Back-to-back frames: i_frame_start in the same cycle as o_frame_done is ignored. It is accepted on the following IDLE cycle.

Test Plan:
- FB_DEPTH=16, i_clear_en=1, i_num_tris=0:
  - 16 consecutive writes, addresses 0..15, pixel 000, Z FF.
  - o_frame_done exactly 16+DRAIN_CYCLES+2 cycles after start.
- i_num_tris=1, triangle (148,105,243)/(172,125,241)/(171,105,243), rasterizer model busy for 40 cycles:
  - o_rast_valid held until busy is seen.
  - Pass-through writes match the model bit-exactly.
  - Ends with o_tris_done=1.
- i_num_tris=3, rasterizer model never raises busy on the second triangle:
  - Culled after 16 cycles.
  - Final o_tris_done=2, o_tris_culled=1.
- i_clear_en=0, i_num_tris=2, i_tri_valid delayed 10 cycles:
  - No clear writes.
  - o_tri_ready stays high while waiting.
  - No o_rast_valid before data is accepted.
- i_rst_n pulsed low at clear address 7:
  - All outputs go to 0 asynchronously.
  - A fresh frame_start restarts the clear at address 0.
  - No o_frame_done from the aborted frame.
- i_frame_start pulsed during RUN:
  - Ignored; o_frame_done pulses once, and o_tris_done equals i_num_tris of the first frame.
